// File: rtl/output_ram_ctrl.sv
// Collects words from two round-robin producers into an 8-entry output RAM,
// then pulses save once the final write has landed, and done one cycle later.
module output_ram_ctrl #(
  parameter  int DATA_W = 32,
  parameter  int DEPTH  = 8,
  localparam int ADDR_W = $clog2(DEPTH),
  localparam int CNT_W  = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              flush,
  input  logic              req0_valid,
  input  logic [DATA_W-1:0] req0_data,
  output logic              req0_ready,
  input  logic              req1_valid,
  input  logic [DATA_W-1:0] req1_data,
  output logic              req1_ready,
  output logic              store,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] val,
  output logic              save,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  count
);

  // state   | meaning
  // IDLE    | waiting for start; count keeps the last frame's total
  // COLLECT | granting producers, one word per cycle
  // LAST    | no grants; final write (if any) is on the RAM port
  // SAVE    | save strobe to the RAM
  // DONE    | done pulse, then back to IDLE
  typedef enum logic [2:0] {
    S_IDLE,
    S_COLLECT,
    S_LAST,
    S_SAVE,
    S_DONE
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   r_wr_ptr;
  logic                r_prio;
  logic                r_store;
  logic [ADDR_W-1:0]   r_addr;
  logic [DATA_W-1:0]   r_val;
  logic [CNT_W-1:0]    r_count;
  logic                w_gnt1;
  logic                w_rdy0;
  logic                w_rdy1;
  logic                w_fire;
  logic                w_ptr_last;

  assign w_ptr_last = (r_wr_ptr == ADDR_W'(DEPTH - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_gnt1      = 1'b0;
    w_rdy0      = 1'b0;
    w_rdy1      = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (start) w_state_nxt = S_COLLECT;
      end
      S_COLLECT: begin
        w_gnt1 = req1_valid && (!req0_valid || r_prio);
        w_rdy1 = w_gnt1;
        w_rdy0 = req0_valid && !w_gnt1;
        // A fire on the last slot ends the frame regardless of flush.
        if ((w_rdy0 || w_rdy1) && w_ptr_last) w_state_nxt = S_LAST;
        else if (flush)                      w_state_nxt = S_LAST;
      end
      S_LAST:  w_state_nxt = S_SAVE;
      S_SAVE:  w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  assign w_fire = w_rdy0 | w_rdy1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_prio   <= 1'b0;
      r_store  <= 1'b0;
      r_addr   <= '0;
      r_val    <= '0;
      r_count  <= '0;
    end else begin
      r_store <= w_fire;
      if (r_state == S_IDLE && start) begin
        r_wr_ptr <= '0;
        r_count  <= '0;
        r_prio   <= 1'b0;
      end
      if (w_fire) begin
        r_addr  <= r_wr_ptr;
        r_val   <= w_gnt1 ? req1_data : req0_data;
        r_count <= r_count + CNT_W'(1);
        if (!w_ptr_last) r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
        if (req0_valid && req1_valid) r_prio <= !w_gnt1;
      end
    end
  end

  assign req0_ready = w_rdy0;
  assign req1_ready = w_rdy1;
  assign store      = r_store;
  assign addr       = r_addr;
  assign val        = r_val;
  assign count      = r_count;
  assign save       = (r_state == S_SAVE);
  assign done       = (r_state == S_DONE);
  assign busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_output_ram_ctrl.sv
// Bench for output_ram_ctrl: a directed vector table, then randomized frames
// checked against a transaction-level round-robin model and a captured RAM image.
module tb_output_ram_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic        flush = 1'b0;
  logic        req0_valid = 1'b0;
  logic [31:0] req0_data = '0;
  logic        req0_ready;
  logic        req1_valid = 1'b0;
  logic [31:0] req1_data = '0;
  logic        req1_ready;
  logic        store;
  logic [2:0]  addr;
  logic [31:0] val;
  logic        save;
  logic        busy;
  logic        done;
  logic [3:0]  count;

  int n_checks = 0;
  int n_err    = 0;
  int n_stores = 0;
  int n_saves  = 0;
  logic [31:0] ram_m [8];

  output_ram_ctrl #(.DATA_W(32), .DEPTH(8)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .flush(flush),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .store(store), .addr(addr), .val(val), .save(save),
    .busy(busy), .done(done), .count(count)
  );

  always #5 clk = ~clk;

  // RAM image as the real memory would see it
  always @(negedge clk) begin
    if (rst_n && store) begin
      ram_m[addr] = val;
      n_stores++;
    end
    if (rst_n && save) n_saves++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic        start, flush, v0, v1;
    logic [31:0] d0, d1;
    logic        r0, r1, st;
    logic [2:0]  ad;
    logic [31:0] vl;
    logic        sv, dn, bz;
    logic [3:0]  cnt;
  } vec_t;

  vec_t tbl [11];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_frame(input int pv0, input int pv1, input int fl_cyc,
                           input logic [31:0] b0, input logic [31:0] b1);
    logic [31:0] q[$];
    bit   acc;
    int   cyc, snap, seq0, seq1, prio;
    logic ev0, ev1, eg0, eg1;
    for (int i = 0; i < 8; i++) ram_m[i] = 32'hDEAD_BEEF;
    snap = n_stores;
    start = 1'b1;
    tick();
    start = 1'b0;
    prio = 0; seq0 = 0; seq1 = 0; acc = 1'b1; cyc = 0;
    while (acc && cyc < 200) begin
      ev0 = ($urandom_range(0, 99) < pv0);
      ev1 = ($urandom_range(0, 99) < pv1);
      req0_valid = ev0;
      req1_valid = ev1;
      req0_data  = b0 + 32'(seq0);
      req1_data  = b1 + 32'(seq1);
      flush      = (cyc == fl_cyc);
      start      = 1'($urandom_range(0, 1));
      #1;
      eg1 = ev1 && (!ev0 || prio == 1);
      eg0 = ev0 && !eg1;
      chk("ready0", {31'b0, req0_ready}, {31'b0, eg0});
      chk("ready1", {31'b0, req1_ready}, {31'b0, eg1});
      if (eg0) begin q.push_back(b0 + 32'(seq0)); seq0++; end
      if (eg1) begin q.push_back(b1 + 32'(seq1)); seq1++; end
      if (ev0 && ev1) prio = eg1 ? 0 : 1;
      if (q.size() == 8 || flush) acc = 1'b0;
      tick();
      cyc++;
    end
    if (acc) begin
      n_checks++;
      n_err++;
      $display("FAIL frame_timeout: frame still collecting after %0d cycles, %0d words", cyc, q.size());
    end
    start = 1'b0; flush = 1'b0;
    req0_valid = 1'b1; req1_valid = 1'b1;
    #1;
    chk("last_ready0", {31'b0, req0_ready}, 32'd0);
    chk("last_ready1", {31'b0, req1_ready}, 32'd0);
    chk("last_save",   {31'b0, save}, 32'd0);
    chk("last_busy",   {31'b0, busy}, 32'd1);
    tick();
    req0_valid = 1'b0; req1_valid = 1'b0;
    #1;
    chk("save_pulse",  {31'b0, save}, 32'd1);
    chk("save_store",  {31'b0, store}, 32'd0);
    tick();
    chk("done_pulse",  {31'b0, done}, 32'd1);
    chk("done_save",   {31'b0, save}, 32'd0);
    chk("done_count",  {28'b0, count}, 32'(q.size()));
    tick();
    chk("idle_busy",   {31'b0, busy}, 32'd0);
    chk("idle_done",   {31'b0, done}, 32'd0);
    chk("idle_count",  {28'b0, count}, 32'(q.size()));
    chk("store_total", 32'(n_stores - snap), 32'(q.size()));
    for (int i = 0; i < q.size(); i++) chk($sformatf("ram[%0d]", i), ram_m[i], q[i]);
  endtask

  initial begin
    int s_snap;
    // start flush v0 v1 d0 d1 | r0 r1 store addr val save done busy count
    tbl[0]  = '{0,1,1,0,32'h05,32'h00, 0,0,0,3'd0,32'h00, 0,0,0,4'd0};
    tbl[1]  = '{1,0,0,0,32'h00,32'h00, 0,0,0,3'd0,32'h00, 0,0,0,4'd0};
    tbl[2]  = '{1,0,1,0,32'h11,32'h00, 1,0,0,3'd0,32'h00, 0,0,1,4'd0};
    tbl[3]  = '{0,0,1,1,32'h12,32'h21, 1,0,1,3'd0,32'h11, 0,0,1,4'd1};
    tbl[4]  = '{0,0,1,1,32'h13,32'h22, 0,1,1,3'd1,32'h12, 0,0,1,4'd2};
    tbl[5]  = '{0,0,0,0,32'h00,32'h00, 0,0,1,3'd2,32'h22, 0,0,1,4'd3};
    tbl[6]  = '{0,1,0,1,32'h00,32'h23, 0,1,0,3'd2,32'h22, 0,0,1,4'd3};
    tbl[7]  = '{0,0,1,0,32'h77,32'h00, 0,0,1,3'd3,32'h23, 0,0,1,4'd4};
    tbl[8]  = '{1,1,0,0,32'h00,32'h00, 0,0,0,3'd3,32'h23, 1,0,1,4'd4};
    tbl[9]  = '{0,0,0,0,32'h00,32'h00, 0,0,0,3'd3,32'h23, 0,1,1,4'd4};
    tbl[10] = '{0,0,1,0,32'h05,32'h00, 0,0,0,3'd3,32'h23, 0,0,0,4'd4};

    #12;
    chk("rst_store", {31'b0, store}, 32'd0);
    chk("rst_busy",  {31'b0, busy}, 32'd0);
    chk("rst_addr",  {29'b0, addr}, 32'd0);
    chk("rst_val",   val, 32'd0);
    chk("rst_count", {28'b0, count}, 32'd0);
    tick();
    rst_n = 1'b1;

    for (int i = 0; i < 11; i++) begin
      start = tbl[i].start; flush = tbl[i].flush;
      req0_valid = tbl[i].v0; req1_valid = tbl[i].v1;
      req0_data = tbl[i].d0;  req1_data = tbl[i].d1;
      #1;
      chk($sformatf("v%0d ready0", i), {31'b0, req0_ready}, {31'b0, tbl[i].r0});
      chk($sformatf("v%0d ready1", i), {31'b0, req1_ready}, {31'b0, tbl[i].r1});
      chk($sformatf("v%0d store", i),  {31'b0, store}, {31'b0, tbl[i].st});
      chk($sformatf("v%0d addr", i),   {29'b0, addr}, {29'b0, tbl[i].ad});
      chk($sformatf("v%0d val", i),    val, tbl[i].vl);
      chk($sformatf("v%0d save", i),   {31'b0, save}, {31'b0, tbl[i].sv});
      chk($sformatf("v%0d done", i),   {31'b0, done}, {31'b0, tbl[i].dn});
      chk($sformatf("v%0d busy", i),   {31'b0, busy}, {31'b0, tbl[i].bz});
      chk($sformatf("v%0d count", i),  {28'b0, count}, {28'b0, tbl[i].cnt});
      tick();
    end
    start = 1'b0; flush = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;

    run_frame(100, 0,   -1, 32'hA0,  32'h0);     // single producer, full frame
    run_frame(100, 100, -1, 32'h100, 32'h200);   // contention, alternating grants
    run_frame(100, 0,    3, 32'hB0,  32'h0);     // flush with a 4th word
    run_frame(0,   0,    0, 32'h0,   32'h0);     // empty flush
    for (int f = 0; f < 8; f++) begin
      int fc;
      fc = ($urandom_range(0, 2) == 0) ? -1 : int'($urandom_range(0, 12));
      run_frame(int'($urandom_range(30, 100)), int'($urandom_range(0, 100)), fc,
                32'h1000 * (f + 1), 32'h8000 + 32'h100 * f);
    end

    // reset in the middle of a frame
    start = 1'b1;
    tick();
    start = 1'b0;
    req0_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      req0_data = 32'hC0 + 32'(k);
      tick();
    end
    s_snap = n_saves;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_store",  {31'b0, store}, 32'd0);
    chk("mid_rst_addr",   {29'b0, addr}, 32'd0);
    chk("mid_rst_val",    val, 32'd0);
    chk("mid_rst_count",  {28'b0, count}, 32'd0);
    chk("mid_rst_busy",   {31'b0, busy}, 32'd0);
    chk("mid_rst_ready0", {31'b0, req0_ready}, 32'd0);
    repeat (3) tick();
    chk("mid_rst_nosave", 32'(n_saves - s_snap), 32'd0);
    rst_n = 1'b1;
    req0_valid = 1'b0;
    tick();
    run_frame(100, 100, 2, 32'h300, 32'h400);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
